// File: rtl/pwm_output_stage.sv
`default_nettype none
// pwm_output_stage -- 16 pins, each off / static high / shared 8-bit PWM; duty is double-buffered
// Rev 1.0
module pwm_output_stage #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_sync
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [15:0]   out_d;
  logic          sync_d;
  logic          tick;
  logic          period_end;
  logic          pwm_raw;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;

  always_comb begin
    en_out     = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    tick       = (pre_q == PRE_LAST);
    period_end = tick && (cnt_q == 8'hFF);
    pre_d      = tick ? '0 : pre_q + PW'(1);
    cnt_d      = tick ? cnt_q + 8'd1 : cnt_q;
    // Shadow only moves at the period boundary so a mid-period write never truncates a pulse
    duty_d     = period_end ? pwm_duty_cycle : duty_q;
    pwm_raw    = (duty_q == 8'hFF) || (cnt_q < duty_q);
    out_d      = en_out & (~en_pwm | {16{pwm_raw}});
    sync_d     = period_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= 8'd0;
      duty_q   <= 8'd0;
      out      <= 16'h0000;
      pwm_sync <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      out      <= out_d;
      pwm_sync <= sync_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_output_stage.sv
`default_nettype none
// tb_pwm_output_stage -- two instances (CLK_DIV 3 and 1) checked against a time-based reference model
// Rev 1.0
module tb_pwm_output_stage;

  localparam int D0 = 3;
  localparam int D1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00, duty = 8'h00;
  logic [15:0] out0, out1;
  logic        sync0, sync1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pwm_output_stage #(.CLK_DIV(D0)) dut0 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out0), .pwm_sync(sync0)
  );

  pwm_output_stage #(.CLK_DIV(D1)) dut1 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .pwm_sync(sync1)
  );

  // Model: position in the period follows from clocks elapsed since reset release
  int unsigned t [2]        = '{0, 0};
  logic [7:0]  shadow [2]   = '{8'h00, 8'h00};
  logic [15:0] exp_out [2]  = '{16'h0000, 16'h0000};
  logic        exp_sync [2] = '{1'b0, 1'b0};

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      int unsigned per, pos;
      logic        raw;
      if (rst) begin
        t[k] = 0; shadow[k] = 8'h00; exp_out[k] = 16'h0000; exp_sync[k] = 1'b0;
      end else begin
        per         = 256 * div_of(k);
        pos         = t[k] % per;
        raw         = (shadow[k] == 8'hFF) || ((pos / div_of(k)) < 32'(shadow[k]));
        exp_out[k]  = {eo_hi, eo_lo} & (~{ep_hi, ep_lo} | {16{raw}});
        exp_sync[k] = (pos == per - 1);
        if (pos == per - 1) shadow[k] = duty;
        t[k]        = t[k] + 1;
      end
    end
  end

  task automatic wait_sync(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((k == 0) ? sync0 : sync1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {eo_hi, eo_lo} = 16'hFFFF; {ep_hi, ep_lo} = 16'hFFFF; duty = 8'h80;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out0 !== 16'h0 || out1 !== 16'h0 || sync0 !== 1'b0 || sync1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold out0=%h out1=%h sync=%b%b expected 0000 0000 00", out0, out1, sync0, sync1);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 256 * D0; i++) begin
      @(negedge clk);
      checks++;
      if (out0 !== 16'h0000) begin
        errors++;
        $display("FAIL first_period i=%0d out0=%h expected 0000", i, out0);
      end
      checks++;
      if (out0 !== exp_out[0] || out1 !== exp_out[1] || sync0 !== exp_sync[0] || sync1 !== exp_sync[1]) begin
        errors++;
        $display("FAIL model_reset t=%0t out0=%h/%h out1=%h/%h sync=%b%b/%b%b", $time,
                 out0, exp_out[0], out1, exp_out[1], sync0, sync1, exp_sync[0], exp_sync[1]);
      end
    end
  endtask

  task automatic test_static();
    @(negedge clk);
    {eo_hi, eo_lo} = 16'hA5A5; {ep_hi, ep_lo} = 16'h0000;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out0 !== 16'hA5A5 || out1 !== 16'hA5A5) begin
        errors++;
        $display("FAIL static out0=%h out1=%h expected a5a5", out0, out1);
      end
    end
  endtask

  task automatic test_duty_half();
    bit ok;
    {eo_hi, eo_lo} = 16'h0001; {ep_hi, ep_lo} = 16'h0001; duty = 8'h80;
    repeat (2) begin
      wait_sync(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL half_sync_timeout got=0 expected=1"); end
    end
    for (int i = 1; i <= 256 * D0; i++) begin
      @(negedge clk);
      checks++;
      if (out0[0] !== (i <= 128 * D0)) begin
        errors++;
        $display("FAIL half_wave i=%0d out0[0]=%b expected %b", i, out0[0], (i <= 128 * D0));
      end
      checks++;
      if (sync0 !== (i == 256 * D0)) begin
        errors++;
        $display("FAIL half_sync i=%0d sync0=%b expected %b", i, sync0, (i == 256 * D0));
      end
    end
  endtask

  task automatic test_glitch();
    bit ok;
    int hi;
    {eo_hi, eo_lo} = 16'h0001; {ep_hi, ep_lo} = 16'h0001; duty = 8'h40;
    wait_sync(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL glitch_sync_timeout got=0 expected=1"); end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      for (int i = 1; i <= 256 * D0; i++) begin
        @(negedge clk);
        if (i == 1) begin
          checks++;
          if (out0[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start period=%0d out0[0]=%b expected 1", p, out0[0]);
          end
        end
        hi += int'(out0[0]);
        if (p == 0 && i == 300) duty = 8'hC0;
      end
      checks++;
      if (hi != ((p == 0) ? 64 * D0 : 192 * D0)) begin
        errors++;
        $display("FAIL glitch_high period=%0d high=%0d expected %0d", p, hi, (p == 0) ? 64 * D0 : 192 * D0);
      end
    end
  endtask

  task automatic test_extremes();
    bit ok;
    logic [7:0] dv;
    {eo_hi, eo_lo} = 16'h0001; {ep_hi, ep_lo} = 16'h0001;
    for (int e = 0; e < 2; e++) begin
      dv   = (e == 0) ? 8'h00 : 8'hFF;
      duty = dv;
      repeat (2) begin
        wait_sync(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL extreme_sync_timeout got=0 expected=1"); end
      end
      for (int i = 0; i < 3 * 256 * D1; i++) begin
        @(negedge clk);
        checks++;
        if (out1[0] !== dv[0]) begin
          errors++;
          $display("FAIL extreme duty=%h i=%0d out1[0]=%b expected %b", dv, i, out1[0], dv[0]);
        end
        checks++;
        if (out0 !== exp_out[0] || out1 !== exp_out[1] || sync0 !== exp_sync[0] || sync1 !== exp_sync[1]) begin
          errors++;
          $display("FAIL model_extreme t=%0t out0=%h/%h out1=%h/%h sync=%b%b/%b%b", $time,
                   out0, exp_out[0], out1, exp_out[1], sync0, sync1, exp_sync[0], exp_sync[1]);
        end
      end
    end
  endtask

  task automatic test_boundary_write();
    logic [7:0] dv;
    int hi, lim;
    {eo_hi, eo_lo} = 16'hFFFF; {ep_hi, ep_lo} = 16'hFFFF;
    for (int n = 0; n < 4; n++) begin
      lim = 0;
      do begin
        @(negedge clk);
        lim++;
      end while ((t[1] % 256) != 255 && lim < 600);
      checks++;
      if (lim >= 600) begin errors++; $display("FAIL boundary_timeout got=%0d expected<600", lim); end
      dv   = (n == 3) ? 8'hFF : 8'($urandom_range(1, 254));
      duty = dv;
      @(negedge clk);
      checks++;
      if (sync1 !== 1'b1) begin errors++; $display("FAIL boundary_sync sync1=%b expected 1", sync1); end
      duty = ~dv;
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        hi += int'(out1[0]);
      end
      checks++;
      if (hi != ((dv == 8'hFF) ? 256 : int'(dv))) begin
        errors++;
        $display("FAIL boundary_high duty=%h high=%0d expected %0d", dv, hi, (dv == 8'hFF) ? 256 : int'(dv));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (out0 !== exp_out[0] || out1 !== exp_out[1] || sync0 !== exp_sync[0] || sync1 !== exp_sync[1]) begin
        errors++;
        $display("FAIL model_random t=%0t out0=%h/%h out1=%h/%h sync=%b%b/%b%b", $time,
                 out0, exp_out[0], out1, exp_out[1], sync0, sync1, exp_sync[0], exp_sync[1]);
      end
      if ($urandom_range(7) == 0) begin
        {eo_hi, eo_lo} = 16'($urandom);
        {ep_hi, ep_lo} = 16'($urandom);
      end
      if ($urandom_range(31) == 0) begin
        case ($urandom_range(3))
          0:       duty = 8'h00;
          1:       duty = 8'hFF;
          default: duty = 8'($urandom);
        endcase
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n, n1;
    {eo_hi, eo_lo} = 16'hFFFF; {ep_hi, ep_lo} = 16'hFFFF; duty = 8'h80;
    repeat (2) begin
      wait_sync(0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_sync_timeout got=0 expected=1"); end
    end
    repeat (100 * D0) @(negedge clk);
    checks++;
    if (out0 !== 16'hFFFF) begin errors++; $display("FAIL midrst_pre out0=%h expected ffff", out0); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out0 !== 16'h0 || out1 !== 16'h0 || sync0 !== 1'b0 || sync1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async out0=%h out1=%h sync=%b%b expected 0000 0000 00", out0, out1, sync0, sync1);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0; n1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (sync1 && n1 == 0) n1 = n;
    end while (!sync0 && n < 2000);
    checks++;
    if (n != 256 * D0) begin errors++; $display("FAIL midrst_first_sync0 clocks=%0d expected %0d", n, 256 * D0); end
    checks++;
    if (n1 != 256 * D1) begin errors++; $display("FAIL midrst_first_sync1 clocks=%0d expected %0d", n1, 256 * D1); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_duty_half();
    test_glitch();
    test_extremes();
    test_boundary_write();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
